div_seq: RTL

- Multi-cycle radix-2 restoring divider and its sequencer for the EX stage (DIV/DIVU).
- The EX stage raises start with the operands and holds them. The block asserts busy so the pipeline controller stalls, then returns {remainder, quotient} for HI/LO writeback.
- One division in flight at a time. Annul aborts an in-flight division on a flush.

---
 rtl/div_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider and its sequencer for the EX stage.
//
// Handles DIV (signed) and DIVU (unsigned). Only one division is in flight at a time.
// The core always divides magnitudes. Signs are put back when the result is registered.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   div_i_start   in   request; EX holds it high until it has consumed the result
//   div_i_signed  in   1 = DIV, 0 = DIVU; sampled on the accept edge
//   div_i_op0     in   dividend; sampled on the accept edge
//   div_i_op1     in   divisor; sampled on the accept edge
//   div_i_annul   in   abort the current division (flush)
//   div_o_result  out  {remainder, quotient}; valid while div_o_ready is high
//   div_o_ready   out  result valid
//   div_o_busy    out  stall request to the pipeline controller
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a start request
// S_DIVZERO | divisor was zero; produce a zero result on the next edge
// S_ON    | iterating, one quotient bit per edge
// S_END   | result valid; hold it until start drops

module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_i_start,
    input  logic                 div_i_signed,
    input  logic [WIDTH-1:0]     div_i_op0,
    input  logic [WIDTH-1:0]     div_i_op1,
    input  logic                 div_i_annul,
    output logic [2*WIDTH-1:0]   div_o_result,
    output logic                 div_o_ready,
    output logic                 div_o_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;      // partial remainder
    logic [WIDTH-1:0]     quo_q, quo_d;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH-1:0]     abs_op0;
    logic [WIDTH-1:0]     abs_op1;
    logic [WIDTH:0]       shifted;
    logic                 trial_ge;
    logic [WIDTH-1:0]     trial_diff;
    logic [WIDTH-1:0]     quo_fin;
    logic [WIDTH-1:0]     rem_fin;

    // Magnitudes. The most negative value maps onto itself, which is still the correct
    // unsigned magnitude.
    assign abs_op0 = (div_i_signed && div_i_op0[WIDTH-1]) ? (~div_i_op0 + 1'b1) : div_i_op0;
    assign abs_op1 = (div_i_signed && div_i_op1[WIDTH-1]) ? (~div_i_op1 + 1'b1) : div_i_op1;

    // One restoring step on the (W+1)-bit shifted remainder.
    // When the top bit is set, the shifted value is at least 2^W and therefore exceeds
    // any divisor. Otherwise a W-bit compare decides. In both cases a W-bit subtract
    // gives the exact difference, because that difference is always below the divisor.
    assign shifted    = {rem_q, quo_q[WIDTH-1]};
    assign trial_ge   = shifted[WIDTH] | (shifted[WIDTH-1:0] >= dvsr_q);
    assign trial_diff = shifted[WIDTH-1:0] - dvsr_q;

    // Negating zero yields zero, so a zero remainder stays zero.
    assign quo_fin = negq_q ? (~quo_q + 1'b1) : quo_q;
    assign rem_fin = negr_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            S_IDLE: begin
                if (div_i_start && !div_i_annul) begin
                    state_d = (div_i_op1 == '0) ? S_DIVZERO : S_ON;
                    negq_d  = div_i_signed & (div_i_op0[WIDTH-1] ^ div_i_op1[WIDTH-1]);
                    negr_d  = div_i_signed & div_i_op0[WIDTH-1];
                    quo_d   = abs_op0;
                    dvsr_d  = abs_op1;
                    rem_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_ON: begin
                if (div_i_annul) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = S_END;
                    result_d = {rem_fin, quo_fin};
                    ready_d  = 1'b1;
                end else begin
                    rem_d = trial_ge ? trial_diff : shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], trial_ge};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIVZERO: begin
                if (div_i_annul) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            S_END: begin
                if (div_i_annul || !div_i_start) begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Stall from the request cycle itself, so EX never advances past an accepted divide.
    // The stall is masked while reset is asserted.
    assign div_o_busy = ~rst & (((state_q == S_IDLE) & div_i_start & ~div_i_annul)
                                | (state_q == S_ON) | (state_q == S_DIVZERO));

    assign div_o_result = result_q;
    assign div_o_ready  = ready_q;

endmodule
